// File: rtl/gate_vector_checker.sv
// Stimulus/response engine for one 2-input gate: walks {a,b} through 00,10,11,01,
// holds each vector HOLD_CYCLES cycles and checks the gate output on the last hold cycle.
module gate_vector_checker #(
    parameter int         HOLD_CYCLES = 100,
    parameter logic [3:0] EXPECT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec,
    output logic       fail_valid,
    output logic [1:0] vec_idx
);

    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    vec_idx_q, vec_idx_d;
    logic          a_q, a_d, b_q, b_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0]    err_count_q, err_count_d;
    logic [1:0]    fail_vec_q, fail_vec_d;
    logic          fail_valid_q, fail_valid_d;
    logic          launch, sample, mismatch;
    logic [2:0]    err_next;

    // Walk order flips a single input per step.
    function automatic logic [1:0] vec_of(input logic [1:0] idx);
        case (idx)
            2'd0:    vec_of = 2'b00;
            2'd1:    vec_of = 2'b10;
            2'd2:    vec_of = 2'b11;
            default: vec_of = 2'b01;
        endcase
    endfunction

    assign launch   = (state_q != S_APPLY) && start;
    assign sample   = (state_q == S_APPLY) && (hold_cnt_q == HOLD_LAST);
    assign mismatch = sample && (dut_out != EXPECT[{a_q, b_q}]);
    assign err_next = err_count_q + 3'(mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_APPLY;
            S_APPLY:        if (sample && vec_idx_q == 2'd3) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        vec_idx_d    = vec_idx_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
        if (launch) begin
            hold_cnt_d   = '0;
            vec_idx_d    = 2'd0;
            {a_d, b_d}   = 2'b00;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            err_count_d  = 3'd0;
            fail_vec_d   = 2'b00;
            fail_valid_d = 1'b0;
        end else if (state_q == S_APPLY) begin
            if (!sample) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end else begin
                hold_cnt_d  = '0;
                err_count_d = err_next;
                if (mismatch && !fail_valid_q) begin
                    fail_vec_d   = {a_q, b_q};
                    fail_valid_d = 1'b1;
                end
                if (vec_idx_q != 2'd3) begin
                    vec_idx_d  = vec_idx_q + 2'd1;
                    {a_d, b_d} = vec_of(vec_idx_q + 2'd1);
                end else begin
                    {a_d, b_d} = 2'b00;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (err_next == 3'd0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q   <= '0;
            vec_idx_q    <= 2'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 3'd0;
            fail_vec_q   <= 2'b00;
            fail_valid_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            vec_idx_q    <= vec_idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;
    assign vec_idx    = vec_idx_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (hold 4 and hold 1) driven by a modelled
// gate (any 4-entry truth table, optional glitching) and checked against an abstract model.
module tb_gate_vector_checker;

    localparam logic [3:0] EXP_TT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r [2];
    logic       dout_r  [2];
    logic       a_w [2], b_w [2], busy_w [2], done_w [2], pass_w [2], fvld_w [2];
    logic [2:0] err_w [2];
    logic [1:0] fvec_w [2], idx_w [2];
    int         hold_of [2] = '{4, 1};
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    gate_vector_checker #(.HOLD_CYCLES(4), .EXPECT(EXP_TT)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .dut_out(dout_r[0]),
        .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fvec_w[0]), .fail_valid(fvld_w[0]), .vec_idx(idx_w[0])
    );

    gate_vector_checker #(.HOLD_CYCLES(1), .EXPECT(EXP_TT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .dut_out(dout_r[1]),
        .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fvec_w[1]), .fail_valid(fvld_w[1]), .vec_idx(idx_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {a,b} applied during step k of the walk.
    function automatic logic [1:0] walk(input int k);
        logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        return tbl[k];
    endfunction

    task automatic chk_reset(input int d);
        chk("rst_ab",    {a_w[d], b_w[d]}, 0);
        chk("rst_busy",  busy_w[d], 0);
        chk("rst_done",  done_w[d], 0);
        chk("rst_pass",  pass_w[d], 0);
        chk("rst_err",   err_w[d], 0);
        chk("rst_fvec",  fvec_w[d], 0);
        chk("rst_fvld",  fvld_w[d], 0);
        chk("rst_idx",   idx_w[d], 0);
    endtask

    // glitch: 0 none, 1 random, 2 always wrong on non-final hold cycles
    task automatic run(input int d, input logic [3:0] f, input int glitch,
                       input int mid_start, input int rst_cyc);
        int         h;
        int         k;
        int         errs;
        logic [1:0] first;
        logic [1:0] ab;
        h = hold_of[d];
        errs = 0;
        first = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (f[walk(i)] != EXP_TT[walk(i)]) begin
                if (errs == 0) first = walk(i);
                errs++;
            end
        end
        @(negedge clk);
        start_r[d] = 1'b1;
        @(negedge clk);
        start_r[d] = 1'b0;
        for (int c = 0; c < 4 * h; c++) begin
            k  = c / h;
            ab = walk(k);
            chk("ab",   {a_w[d], b_w[d]}, ab);
            chk("busy", busy_w[d], 1);
            chk("vidx", idx_w[d], k);
            chk("done_lo", done_w[d], 0);
            if (c == 0) begin
                chk("clr_err",  err_w[d], 0);
                chk("clr_fvld", fvld_w[d], 0);
                chk("clr_pass", pass_w[d], 0);
            end
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_reset(d);
                #1 rst_n = 1'b1;
                @(negedge clk);
                chk_reset(d);
                return;
            end
            dout_r[d] = f[ab];
            if ((c % h) != h - 1) begin
                if (glitch == 2 || (glitch == 1 && $urandom_range(0, 1) == 1))
                    dout_r[d] = ~f[ab];
            end
            start_r[d] = (c == mid_start);
            @(negedge clk);
        end
        start_r[d] = 1'b0;
        dout_r[d]  = $urandom_range(0, 1) == 1;
        for (int r = 0; r < 2; r++) begin
            chk("done",  done_w[d], 1);
            chk("busy_lo", busy_w[d], 0);
            chk("ab_idle", {a_w[d], b_w[d]}, 0);
            chk("err",   err_w[d], errs);
            chk("pass",  pass_w[d], errs == 0);
            chk("fvld",  fvld_w[d], errs != 0);
            if (errs != 0) chk("fvec", fvec_w[d], first);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start_r[0] = 1'b0; start_r[1] = 1'b0;
        dout_r[0]  = 1'b0; dout_r[1]  = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 4'b1000, 0, -1, -1);   // correct AND
        run(0, 4'b0000, 0, -1, -1);   // stuck at 0
        run(0, 4'b1111, 0, -1, -1);   // stuck at 1
        run(0, 4'b1000, 2, -1, -1);   // glitching AND
        run(0, 4'b1000, 0,  5, -1);   // start during APPLY ignored
        run(0, 4'b1000, 0, -1,  6);   // reset mid-run
        run(0, 4'b1000, 0, -1, -1);   // clean rerun
        run(1, 4'b1110, 0, -1, -1);   // OR with AND expectations
        run(1, 4'b1110, 0, -1, -1);   // restart from DONE
        for (int n = 0; n < 24; n++) begin
            int d;
            d = $urandom_range(0, 1);
            run(d, 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * hold_of[d] - 1) : -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus and response engine for a single 2-input combinational gate. It drives the gate's `a`/`b` inputs through the fixed walk 00 → 10 → 11 → 01 and holds each vector for a programmable number of cycles. On the last cycle of each hold it samples the gate output, compares it against a parameterised truth table, and records the errors. It lets gate blocks such as `my_AND` be checked in hardware or in a plain clocked bench without `$monitor` inspection.

## Interface
Parameters:
- `HOLD_CYCLES`, 100, cycles each vector is driven; legal range ≥ 1.
- `EXPECT`, 4'b1000, expected output indexed by `{a,b}`: bit 3 is the expected value for a=1,b=1 and bit 0 for a=0,b=0. The default is AND.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `dut_out` in 1: gate output under test.
- `a` out 1: gate input a.
- `b` out 1: gate input b.
- `busy` out 1: high while vectors are being applied.
- `done` out 1: high in DONE, stays high until the next start or reset.
- `pass` out 1: valid when `done` is high; 1 iff `err_count` == 0.
- `err_count` out 3: number of mismatching vectors, 0..4.
- `fail_vec` out 2: `{a,b}` of the first mismatch; valid only when `fail_valid` is high.
- `fail_valid` out 1: at least one mismatch seen in the current run.
- `vec_idx` out 2: index 0..3 of the vector currently applied.

## Operation
- States:
  - IDLE: outputs at reset values.
  - APPLY: drives vectors.
  - DONE: results held.
- Vector table, indexed by `vec_idx`: 0→{0,0}, 1→{1,0}, 2→{1,1}, 3→{0,1}. Only one input toggles per step.
- Internal `hold_cnt` is wide enough for HOLD_CYCLES-1. It counts 0..HOLD_CYCLES-1 and wraps at the end of each vector.
- IDLE or DONE with `start`=1:
  - Go to APPLY with `vec_idx`=0, `hold_cnt`=0.
  - Clear `err_count`, `fail_valid`, `fail_vec`, `pass`, `done`.
- APPLY with `hold_cnt` < HOLD_CYCLES-1: increment `hold_cnt`; `dut_out` is ignored, so glitches and settling are tolerated.
- APPLY with `hold_cnt` == HOLD_CYCLES-1, the sample edge:
  - Compare `dut_out` with `EXPECT[{a,b}]`.
  - On mismatch: increment `err_count`. If `fail_valid` was 0, capture `fail_vec`={a,b} and set `fail_valid`.
  - If `vec_idx` < 3: increment `vec_idx` and clear `hold_cnt`.
  - If `vec_idx` == 3: go to DONE.
- DONE:
  - `a`=`b`=0, `busy`=0, `done`=1, `pass`=(`err_count`==0).
  - Results hold until `start` or reset.
- `start` asserted during APPLY is ignored. There is no queuing and no restart.
- `err_count` cannot exceed 4, so it never overflows.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - State IDLE; `a`=`b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_valid`=0, `vec_idx`=0.
  - `hold_cnt`=0.
- Reset mid-run aborts immediately; no partial results are retained.
- `a`, `b`, `busy`, `done`, `pass` are registered outputs, not decoded from state combinationally.
- Run timeline, with `start` sampled at edge E:
  - After E: `busy`=1, `a`/`b`=00.
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - The vector-k sample happens at edge E+(k+1)·HOLD_CYCLES; the new vector appears after that same edge.
  - After edge E+4·HOLD_CYCLES: `done`=1, `busy`=0.
  - Start-to-done latency is 4·HOLD_CYCLES cycles.
- HOLD_CYCLES=1: every APPLY cycle is a sample edge, and the vector changes every cycle.
- Sampling on the final hold cycle is the only check point. The DUT gets HOLD_CYCLES-1 cycles to settle.

## Test plan
- Correct AND model, HOLD_CYCLES=4, `start` pulse → `a`,`b` sequence 00,10,11,01, each held 4 cycles; `done`=1 sixteen cycles after start; `err_count`=0, `pass`=1, `fail_valid`=0.
- DUT output stuck at 0 → `err_count`=1, `fail_vec`=2'b11, `fail_valid`=1, `pass`=0.
- DUT output stuck at 1 → `err_count`=3, `fail_vec`=2'b00 (first mismatch at vector 0), `pass`=0.
- Correct model that glitches to the wrong value on every non-final hold cycle, HOLD_CYCLES=4 → `err_count`=0, `pass`=1.
- `start` re-asserted mid-run → timeline unchanged. `rst_n` pulsed low at cycle 6 → all outputs return to reset values at once. A following `start` produces a clean full run.
- HOLD_CYCLES=1 with an OR model and EXPECT default → `done` 4 cycles after start; `err_count`=2 (vectors 10 and 01), `fail_vec`=2'b10. A second `start` from DONE clears the results and reruns.
